// File: rtl/jedro_1_wb_arbiter_if.sv
// Write-back bus between the ALU/LSU producers, decode issue port and the
// register-file arbiter, including the pending-write scoreboard.
interface jedro_1_wb_arbiter_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    localparam int NUM_REGISTERS = 2 ** REG_ADDR_WIDTH;

    logic                      alu_valid_i;
    logic [REG_ADDR_WIDTH-1:0] alu_addr_i;
    logic [DATA_WIDTH-1:0]     alu_data_i;
    logic                      alu_ready_o;

    logic                      lsu_valid_i;
    logic [REG_ADDR_WIDTH-1:0] lsu_addr_i;
    logic [DATA_WIDTH-1:0]     lsu_data_i;
    logic                      lsu_ready_o;

    logic                      wpc_we_o;
    logic [REG_ADDR_WIDTH-1:0] wpc_addr_o;
    logic [DATA_WIDTH-1:0]     wpc_data_o;

    logic                      issue_valid_i;
    logic [REG_ADDR_WIDTH-1:0] issue_addr_i;
    logic [NUM_REGISTERS-1:0]  busy_o;

    modport slave (
        input  alu_valid_i, alu_addr_i, alu_data_i,
        output alu_ready_o,
        input  lsu_valid_i, lsu_addr_i, lsu_data_i,
        output lsu_ready_o,
        output wpc_we_o, wpc_addr_o, wpc_data_o,
        input  issue_valid_i, issue_addr_i,
        output busy_o
    );

    modport master (
        output alu_valid_i, alu_addr_i, alu_data_i,
        input  alu_ready_o,
        output lsu_valid_i, lsu_addr_i, lsu_data_i,
        input  lsu_ready_o,
        input  wpc_we_o, wpc_addr_o, wpc_data_o,
        output issue_valid_i, issue_addr_i,
        input  busy_o
    );
endinterface

// File: rtl/jedro_1_wb_arbiter.sv
// Round-robin write-back arbiter between ALU and LSU feeding one register-file
// write port, plus a scoreboard of registers awaiting write-back.
module jedro_1_wb_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input logic                clk_i,
    input logic                rst_i,
    jedro_1_wb_arbiter_if.slave wb
);
    localparam int NUM_REGISTERS = 2 ** REG_ADDR_WIDTH;

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_LSU = 1'b1
    } grant_e;

    grant_e                    last_grant;
    logic                      alu_ready;
    logic                      lsu_ready;
    logic                      accept;
    logic [REG_ADDR_WIDTH-1:0] sel_addr_p0;
    logic [DATA_WIDTH-1:0]     sel_data_p0;
    logic [NUM_REGISTERS-1:0]  set_mask;
    logic [NUM_REGISTERS-1:0]  clr_mask;
    logic [NUM_REGISTERS-1:0]  busy_next;

    logic                      wpc_we_p1;
    logic [REG_ADDR_WIDTH-1:0] wpc_addr_p1;
    logic [DATA_WIDTH-1:0]     wpc_data_p1;
    logic [NUM_REGISTERS-1:0]  busy_p1;

    // One-hot of a register index; x0 never appears in the scoreboard.
    function automatic logic [NUM_REGISTERS-1:0] reg_mask(
        input logic                      en,
        input logic [REG_ADDR_WIDTH-1:0] addr
    );
        reg_mask = '0;
        if (en && (addr != '0)) begin
            reg_mask[addr] = 1'b1;
        end
    endfunction

    // Stage p0: grant and select; contention goes to whoever was not granted last.
    always_comb begin
        alu_ready   = !rst_i && wb.alu_valid_i &&
                      (!wb.lsu_valid_i || (last_grant == GRANT_LSU));
        lsu_ready   = !rst_i && wb.lsu_valid_i &&
                      (!wb.alu_valid_i || (last_grant == GRANT_ALU));
        accept      = alu_ready || lsu_ready;
        sel_addr_p0 = lsu_ready ? wb.lsu_addr_i : wb.alu_addr_i;
        sel_data_p0 = lsu_ready ? wb.lsu_data_i : wb.alu_data_i;
        set_mask    = reg_mask(wb.issue_valid_i, wb.issue_addr_i);
        clr_mask    = reg_mask(wpc_we_p1, wpc_addr_p1);
        busy_next   = (busy_p1 & ~clr_mask) | set_mask;
    end

    // Stage p1: registered write port and scoreboard.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant  <= GRANT_ALU;
            wpc_we_p1   <= 1'b0;
            wpc_addr_p1 <= '0;
            wpc_data_p1 <= '0;
            busy_p1     <= '0;
        end else begin
            wpc_we_p1 <= accept && (sel_addr_p0 != '0);
            if (accept) begin
                last_grant  <= lsu_ready ? GRANT_LSU : GRANT_ALU;
                wpc_addr_p1 <= sel_addr_p0;
                wpc_data_p1 <= sel_data_p0;
            end
            busy_p1 <= busy_next;
        end
    end

    assign wb.alu_ready_o = alu_ready;
    assign wb.lsu_ready_o = lsu_ready;
    assign wb.wpc_we_o    = wpc_we_p1;
    assign wb.wpc_addr_o  = wpc_addr_p1;
    assign wb.wpc_data_o  = wpc_data_p1;
    assign wb.busy_o      = busy_p1;

endmodule

// File: tb/tb_jedro_1_wb_arbiter.sv
// Directed self-checking bench for the write-back arbiter and its scoreboard.
module tb_jedro_1_wb_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk_i = ~clk_i;

    jedro_1_wb_arbiter_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) bus ();

    jedro_1_wb_arbiter #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .wb    (bus.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                         input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ld);
        bus.alu_valid_i = av; bus.alu_addr_i = aa; bus.alu_data_i = ad;
        bus.lsu_valid_i = lv; bus.lsu_addr_i = la; bus.lsu_data_i = ld;
    endtask

    task automatic issue(input logic v, input logic [AW-1:0] a);
        bus.issue_valid_i = v; bus.issue_addr_i = a;
    endtask

    // Registered outputs are checked at the negedge, then inputs are driven
    // and ready is checked 1 time unit later, well before the next posedge.
    task automatic next_cycle();
        @(negedge clk_i);
    endtask

    task automatic chk_ready(input string tag, input logic exp_alu, input logic exp_lsu);
        #1;
        chk({tag, "_alu_rdy"}, 64'(bus.alu_ready_o), 64'(exp_alu));
        chk({tag, "_lsu_rdy"}, 64'(bus.lsu_ready_o), 64'(exp_lsu));
    endtask

    task automatic chk_wpc(input string tag, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        chk({tag, "_we"},   64'(bus.wpc_we_o),   64'(we));
        chk({tag, "_addr"}, 64'(bus.wpc_addr_o), 64'(a));
        chk({tag, "_data"}, 64'(bus.wpc_data_o), 64'(d));
    endtask

    initial begin
        // Reset with everything asserted: nothing may be granted or recorded.
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
        issue(1'b1, 5'd3);
        next_cycle();
        chk_wpc("rst", 1'b0, 5'd0, 32'd0);
        chk("rst_busy", 64'(bus.busy_o), 64'd0);
        chk_ready("rst", 1'b0, 1'b0);
        next_cycle();
        chk("rst_busy_noissue", 64'(bus.busy_o), 64'd0);
        chk("rst_we_hold", 64'(bus.wpc_we_o), 64'd0);
        rst_i = 1'b0;
        issue(1'b0, 5'd0);

        // Contention after reset: LSU, ALU, LSU, ALU.
        drive(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB2);
        chk_ready("rr0", 1'b0, 1'b1);
        next_cycle();
        chk_wpc("rr0_wpc", 1'b1, 5'd2, 32'hB2);
        chk_ready("rr1", 1'b1, 1'b0);
        next_cycle();
        chk_wpc("rr1_wpc", 1'b1, 5'd1, 32'hA1);
        chk_ready("rr2", 1'b0, 1'b1);
        next_cycle();
        chk_wpc("rr2_wpc", 1'b1, 5'd2, 32'hB2);
        chk_ready("rr3", 1'b1, 1'b0);
        next_cycle();
        chk_wpc("rr3_wpc", 1'b1, 5'd1, 32'hA1);

        // ALU alone, same-cycle grant, one-cycle write latency.
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        chk_ready("alu", 1'b1, 1'b0);
        next_cycle();
        chk_wpc("alu_wpc", 1'b1, 5'd5, 32'hDEADBEEF);
        drive(1'b0, 5'd6, 32'h66, 1'b0, 5'd7, 32'h77);
        chk_ready("idle", 1'b0, 1'b0);
        next_cycle();
        chk_wpc("idle_hold", 1'b0, 5'd5, 32'hDEADBEEF);

        // LSU back-to-back stream.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(10 + i), 32'(32'h100 + i));
            chk_ready($sformatf("lsu_s%0d", i), 1'b0, 1'b1);
            next_cycle();
            chk_wpc($sformatf("lsu_s%0d_wpc", i), 1'b1, 5'(10 + i), 32'(32'h100 + i));
        end

        // Write to x0: granted but not written.
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234);
        chk_ready("x0", 1'b0, 1'b1);
        next_cycle();
        chk_wpc("x0_wpc", 1'b0, 5'd0, 32'h1234);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // Scoreboard: issue rd=7 in cycle 1, write-back accepted in cycle 3.
        issue(1'b1, 5'd7);
        next_cycle();
        chk("sb7_c2", 64'(bus.busy_o[7]), 64'd1);
        issue(1'b0, 5'd0);
        next_cycle();
        chk("sb7_c3", 64'(bus.busy_o[7]), 64'd1);
        drive(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0);
        chk_ready("sb7_wb", 1'b1, 1'b0);
        next_cycle();
        chk("sb7_c4", 64'(bus.busy_o[7]), 64'd1);
        chk_wpc("sb7_wpc", 1'b1, 5'd7, 32'h77);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        next_cycle();
        chk("sb7_c5", 64'(bus.busy_o), 64'd0);

        // Same-cycle set and clear of rd=9: set wins.
        issue(1'b1, 5'd9);
        next_cycle();
        issue(1'b0, 5'd0);
        drive(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0);
        next_cycle();
        chk("sb9_we", 64'(bus.wpc_we_o), 64'd1);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        issue(1'b1, 5'd9);
        next_cycle();
        chk("sb9_setwins", 64'(bus.busy_o), 64'h200);
        issue(1'b0, 5'd0);
        next_cycle();
        chk("sb9_stays", 64'(bus.busy_o), 64'h200);

        // Clear of 9 alongside set of 6, then an issue to x0.
        drive(1'b1, 5'd9, 32'h999, 1'b0, 5'd0, 32'd0);
        next_cycle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        issue(1'b1, 5'd6);
        next_cycle();
        chk("sb_both", 64'(bus.busy_o), 64'h40);
        issue(1'b1, 5'd0);
        next_cycle();
        chk("sb_x0", 64'(bus.busy_o), 64'h40);

        // Reset right after an accept while rd=7 is busy.
        issue(1'b1, 5'd7);
        drive(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'd0);
        next_cycle();
        chk("pre_rst_busy", 64'(bus.busy_o), 64'hC0);
        issue(1'b0, 5'd0);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        next_cycle();
        chk("pre_rst_busy2", 64'(bus.busy_o), 64'h80);
        drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
        chk_ready("pre_rst_acc", 1'b1, 1'b0);
        next_cycle();
        chk_wpc("pre_rst_wpc", 1'b1, 5'd3, 32'h33);
        rst_i = 1'b1;
        chk_ready("in_rst", 1'b0, 1'b0);
        next_cycle();
        chk_wpc("post_rst", 1'b0, 5'd0, 32'd0);
        chk("post_rst_busy", 64'(bus.busy_o), 64'd0);
        rst_i = 1'b0;

        // Last grant is back to ALU, so contention grants LSU first.
        drive(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB2);
        chk_ready("post_rst_rr", 1'b0, 1'b1);
        next_cycle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/jedro_1_wb_arbiter.md
JEDRO_1_WB_ARBITER -- requirements
Module: jedro_1_wb_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of write-back data.
REQ-002 Parameter REG_ADDR_WIDTH, default 5: register address width; NUM_REGISTERS = 2**REG_ADDR_WIDTH.
REQ-003 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_i  input  1  reset; synchronous, active-high.
REQ-005 alu_valid_i  input  1  ALU has a write-back pending.
REQ-006 alu_addr_i  input  REG_ADDR_WIDTH  ALU destination register.
REQ-007 alu_data_i  input  DATA_WIDTH  ALU result.
REQ-008 alu_ready_o  output  1  ALU request granted this cycle (combinational).
REQ-009 lsu_valid_i / lsu_addr_i / lsu_data_i / lsu_ready_o: same as REQ-005..008, for the load-store unit.
REQ-010 wpc_we_o  output  1  register-file write enable (registered).
REQ-011 wpc_addr_o  output  REG_ADDR_WIDTH  register-file write address (registered).
REQ-012 wpc_data_o  output  DATA_WIDTH  register-file write data (registered).
REQ-013 issue_valid_i  input  1  decode issues an instruction that will write issue_addr_i.
REQ-014 issue_addr_i  input  REG_ADDR_WIDTH  destination of the issued instruction.
REQ-015 busy_o  output  NUM_REGISTERS  pending-write scoreboard; bit n = register n awaits write-back.

Function
REQ-016 A request is accepted in a cycle when valid_i and ready_o are both 1 for that requester.
REQ-017 At most one ready_o is 1 per cycle; ready_o is never 1 while the matching valid_i is 0.
REQ-018 Only one requester valid: it is granted the same cycle.
REQ-019 Both valid: grant goes to the requester not granted most recently (round-robin); a 1-bit last_grant register updates on every accept.
REQ-020 last_grant resets to ALU, so the first contended cycle after reset grants LSU.
REQ-021 Accept in cycle N: wpc_addr_o/wpc_data_o carry the accepted addr/data in cycle N+1; wpc_we_o = 1 in N+1 unless addr == 0.
REQ-022 No accept in cycle N: wpc_we_o = 0 in N+1; wpc_addr_o/wpc_data_o hold their previous values.
REQ-023 A write to x0 is accepted (ready_o = 1) and discarded: wpc_we_o stays 0.
REQ-024 Throughput is one write-back per cycle; a back-to-back stream from one requester is granted every cycle when the other requester is idle.
REQ-025 A valid request that is not granted stays pending; requesters hold valid, addr and data stable until accepted.
REQ-026 Scoreboard set: issue_valid_i = 1 and issue_addr_i != 0 in cycle N: busy_o[issue_addr_i] = 1 from N+1.
REQ-027 Scoreboard clear: wpc_we_o = 1 in cycle M: busy_o[wpc_addr_o] = 0 from M+1, after the register file has captured the write.
REQ-028 Set and clear of the same register in the same cycle: set wins, so the bit stays 1 for the newer producer.
REQ-029 Set and clear of different registers in the same cycle both take effect.
REQ-030 busy_o[0] is constant 0; issue to x0 is ignored.
REQ-031 Issuing to an already-busy register leaves it busy; no producer count is kept, and the first write-back clears it.

Reset
REQ-032 rst_i = 1 at a rising edge gives, in the following cycle: wpc_we_o = 0, wpc_addr_o = 0, wpc_data_o = 0, busy_o = 0, last_grant = ALU.
REQ-033 While rst_i = 1: alu_ready_o = lsu_ready_o = 0; no request is accepted and no issue is recorded.
REQ-034 Reset asserted mid-operation discards any accepted-but-not-written transfer; wpc_we_o = 0 in the cycle after reset asserts.

Verification
REQ-035 ALU only, valid with addr = 5, data = 0xDEADBEEF in cycle N -> alu_ready_o = 1 in N; wpc_we_o = 1, wpc_addr_o = 5, wpc_data_o = 0xDEADBEEF in N+1.
REQ-036 Both valid for 4 cycles after reset -> grant order LSU, ALU, LSU, ALU; exactly one ready_o per cycle.
REQ-037 LSU writes addr = 0, data = 0x1234 -> lsu_ready_o = 1; wpc_we_o = 0 in the next cycle.
REQ-038 Issue rd = 7 in cycle 1 and ALU write-back to 7 accepted in cycle 3 -> busy_o[7] = 1 in cycles 2..4 and 0 from cycle 5.
REQ-039 Same-cycle issue to rd = 9 and wpc_we_o with wpc_addr_o = 9 -> busy_o[9] remains 1.
REQ-040 rst_i pulsed the cycle after an accept with busy_o = 0x0000_0080 -> wpc_we_o = 0 and busy_o = 0 in the cycle after reset.
